ahb_lite_rif_bridge: RTL
========================

AHB_LITE_RIF_BRIDGE -- requirements
Module: ahb_lite_rif_bridge

Interface
REQ-001 Parameter ADDR_WIDTH, default 12, is the HADDR and rif_addr width.
REQ-002 Parameter DATA_WIDTH, default 32, is the data bus width; legal values are 8..1024, powers of 2 only; any other value SHALL be a $fatal at elaboration.
REQ-003 Parameter TIMEOUT, default 0, is the maximum number of wait cycles per register access; 0 disables the timeout.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-005 HCLK  in  1  clock; all flops on rising edge.
REQ-006 HRESET  in  1  asynchronous active-high reset.
REQ-007 HSEL  in  1  slave select.
REQ-008 HADDR  in  ADDR_WIDTH  byte address (address phase).
REQ-009 HTRANS  in  2  transfer type; HTRANS[1]=1 means NONSEQ/SEQ.
REQ-010 HWRITE  in  1  1=write.
REQ-011 HSIZE  in  3  transfer size, log2 bytes.
REQ-012 HWDATA  in  DATA_WIDTH  write data (data phase).
REQ-013 HREADY  in  1  bus-level ready.
REQ-014 HREADYOUT  out  1  slave ready.
REQ-015 HRESP  out  1  1=ERROR.
REQ-016 HRDATA  out  DATA_WIDTH  read data.
REQ-017 rif_addr  out  ADDR_WIDTH  latched address.
REQ-018 rif_wr_req  out  1  write request, held until rif_ready.
REQ-019 rif_rd_req  out  1  read request, held until rif_ready.
REQ-020 rif_wstrb  out  DATA_WIDTH/8  address-aligned byte strobes.
REQ-021 rif_wdata  out  DATA_WIDTH  write data, strobe-masked.
REQ-022 rif_rdata  in  DATA_WIDTH  read data, valid with rif_ready.
REQ-023 rif_ready  in  1  access complete this cycle.
REQ-024 rif_err  in  1  access failed; sampled only when rif_ready=1.

Function
REQ-025 A transfer SHALL be accepted on a rising edge when HSEL=1, HREADY=1 and HTRANS[1]=1; HADDR, HWRITE and HSIZE SHALL be latched at that edge.
REQ-026 A selected IDLE or BUSY transfer SHALL get a zero-wait OKAY and SHALL NOT issue a RIF request.
REQ-027 The state machine SHALL have states IDLE, ACCESS, ERR1 and ERR2, and SHALL reset to IDLE.
REQ-028 On acceptance of a legal transfer, the next state SHALL be ACCESS.
REQ-029 A transfer SHALL be illegal if HSIZE > log2(DATA_WIDTH/8) or if HADDR is not aligned to 2^HSIZE; an illegal transfer SHALL go to ERR1 with no RIF request.
REQ-030 rif_wstrb SHALL be ((1<<2^size)-1) << (addr mod DATA_WIDTH/8); rif_wdata byte lanes with strobe 0 SHALL be 0.
REQ-031 In ACCESS, exactly one of rif_wr_req/rif_rd_req SHALL be 1, according to the latched write bit; rif_addr, rif_wstrb and rif_wdata SHALL be stable until rif_ready.
REQ-032 In ACCESS, HREADYOUT SHALL be rif_ready & ~rif_err (combinational); otherwise the slave inserts wait states.
REQ-033 If rif_ready=1 and rif_err=0, the transfer SHALL complete OKAY that cycle; HRDATA SHALL be rif_rdata masked by strobe for reads and 0 otherwise.
REQ-034 The next state after a completing ACCESS cycle SHALL be ACCESS if a new transfer is accepted at that same edge (pipelined), else IDLE.
REQ-035 If rif_ready=1 and rif_err=1, the next state SHALL be ERR1 and the requests SHALL drop.
REQ-036 With TIMEOUT>0, a wait counter SHALL clear on entry to ACCESS and increment on each cycle with rif_ready=0; when it reaches TIMEOUT, requests SHALL drop and the next state SHALL be ERR1.
REQ-037 ERR1 SHALL drive HREADYOUT=0, HRESP=1; the next state SHALL be ERR2.
REQ-038 ERR2 SHALL drive HREADYOUT=1, HRESP=1; the next state SHALL be ACCESS or ERR1 if a transfer is accepted, else IDLE.
REQ-039 In IDLE, the block SHALL drive HREADYOUT=1, HRESP=0, HRDATA=0 and no RIF requests.
REQ-040 If HSEL=0 during ACCESS, the access SHALL still run to completion; AHB protocol guarantees that the master holds the data phase.

Reset
REQ-041 While HRESET=1: state=IDLE, HREADYOUT=1, HRESP=0, HRDATA=0, rif_wr_req=rif_rd_req=0, rif_addr=0, rif_wstrb=0, wait counter=0; an assertion of HRESET mid-ACCESS SHALL abort immediately with no completion.

Verification
REQ-042 Zero-wait write: rif_ready tied 1, NONSEQ write HADDR=0x004, HSIZE=2, HWDATA=0xDEADBEEF -> rif_wr_req=1 for 1 cycle, rif_wstrb=4'hF, HREADYOUT=1 throughout, HRESP=0.
REQ-043 Byte read with waits: HADDR=0x013, HSIZE=0, rif_ready after 3 cycles, rif_rdata=0xAABBCCDD -> HREADYOUT=0 for 3 cycles, rif_wstrb=4'b1000, HRDATA=0xAA000000.
REQ-044 Misaligned: HADDR=0x002, HSIZE=2 -> no RIF request, HREADYOUT 0 then 1, HRESP=1 for both cycles.
REQ-045 Timeout: TIMEOUT=4, rif_ready held 0 -> requests drop after 4 wait cycles, then a two-cycle ERROR response follows.
REQ-046 Back-to-back: 2 NONSEQ writes with the second address phase on the first completion edge -> two consecutive ACCESS periods with no IDLE between; HRESET pulsed mid-ACCESS -> all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/ahb_lite_rif_bridge_if.sv
// Bus bundle for the AHB-Lite to register-interface bridge: AHB slave side
// plus the simple request/ready register port.
interface ahb_lite_rif_bridge_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
);
    logic                    HSEL;
    logic [ADDR_WIDTH-1:0]   HADDR;
    logic [1:0]              HTRANS;
    logic                    HWRITE;
    logic [2:0]              HSIZE;
    logic [DATA_WIDTH-1:0]   HWDATA;
    logic                    HREADY;
    logic                    HREADYOUT;
    logic                    HRESP;
    logic [DATA_WIDTH-1:0]   HRDATA;

    logic [ADDR_WIDTH-1:0]   rif_addr;
    logic                    rif_wr_req;
    logic                    rif_rd_req;
    logic [DATA_WIDTH/8-1:0] rif_wstrb;
    logic [DATA_WIDTH-1:0]   rif_wdata;
    logic [DATA_WIDTH-1:0]   rif_rdata;
    logic                    rif_ready;
    logic                    rif_err;

    // Bridge view.
    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
        output HREADYOUT, HRESP, HRDATA,
        output rif_addr, rif_wr_req, rif_rd_req, rif_wstrb, rif_wdata,
        input  rif_rdata, rif_ready, rif_err
    );

    // Bus master plus register-file view.
    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
        input  HREADYOUT, HRESP, HRDATA,
        input  rif_addr, rif_wr_req, rif_rd_req, rif_wstrb, rif_wdata,
        output rif_rdata, rif_ready, rif_err
    );
endinterface

// File: rtl/ahb_lite_rif_bridge.sv
// AHB-Lite slave that turns each legal transfer into one held request on a
// simple register interface, with optional wait timeout and two-cycle ERROR.
module ahb_lite_rif_bridge #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 0
) (
    input  logic                 HCLK,
    input  logic                 HRESET,
    ahb_lite_rif_bridge_if.slave bus
);
    localparam int NB     = DATA_WIDTH / 8;
    localparam int LOG2NB = (NB > 1) ? $clog2(NB) : 0;
    localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    if (DATA_WIDTH < 8 || DATA_WIDTH > 1024 || (DATA_WIDTH & (DATA_WIDTH - 1)) != 0) begin : g_bad_width
        $fatal(1, "ahb_lite_rif_bridge: DATA_WIDTH must be a power of 2 in 8..1024");
    end

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_ERR1, S_ERR2} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  write_q, write_d;
    logic [NB-1:0]         strb_q, strb_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    logic                  accept;
    logic                  legal;
    logic                  take;
    logic                  timeout_hit;
    logic [NB-1:0]         strb_new;
    logic [DATA_WIDTH-1:0] lane_mask;
    logic [31:0]           haddr32;
    logic [31:0]           off;
    logic [31:0]           nbytes;

    assign accept      = bus.HSEL && bus.HREADY && bus.HTRANS[1];
    assign timeout_hit = (TIMEOUT > 0) && (cnt_q == CNT_W'(TIMEOUT - 1));

    // Address-phase decode: legality and the byte lanes the transfer covers.
    always_comb begin
        haddr32  = 32'(bus.HADDR);
        nbytes   = 32'd1 << bus.HSIZE;
        off      = haddr32 & 32'(NB - 1);
        legal    = ({29'd0, bus.HSIZE} <= 32'(LOG2NB)) &&
                   ((haddr32 & (nbytes - 32'd1)) == 32'd0);
        strb_new = '0;
        for (int b = 0; b < NB; b++) begin
            strb_new[b] = (32'(b) >= off) && (32'(b) < off + nbytes);
        end
    end

    always_comb begin
        lane_mask = '0;
        for (int b = 0; b < NB; b++) begin
            lane_mask[b*8 +: 8] = {8{strb_q[b]}};
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            write_q <= 1'b0;
            strb_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            strb_q  <= strb_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        write_d        = write_q;
        strb_d         = strb_q;
        cnt_d          = cnt_q;
        take           = 1'b0;
        bus.HREADYOUT  = 1'b1;
        bus.HRESP      = 1'b0;
        bus.HRDATA     = '0;
        bus.rif_wr_req = 1'b0;
        bus.rif_rd_req = 1'b0;
        bus.rif_wdata  = '0;

        case (state_q)
            S_IDLE: take = 1'b1;
            S_ACCESS: begin
                bus.rif_wr_req = write_q;
                bus.rif_rd_req = ~write_q;
                // HWDATA is held by the master for the whole data phase.
                bus.rif_wdata  = write_q ? (bus.HWDATA & lane_mask) : '0;
                bus.HREADYOUT  = bus.rif_ready & ~bus.rif_err;
                if (bus.rif_ready) begin
                    if (bus.rif_err) begin
                        state_d = S_ERR1;
                    end else begin
                        take    = 1'b1;
                        state_d = S_IDLE;
                        if (!write_q) bus.HRDATA = bus.rif_rdata & lane_mask;
                    end
                end else if (timeout_hit) begin
                    state_d = S_ERR1;
                end else if (TIMEOUT > 0) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_ERR1: begin
                bus.HREADYOUT = 1'b0;
                bus.HRESP     = 1'b1;
                state_d       = S_ERR2;
            end
            S_ERR2: begin
                bus.HRESP = 1'b1;
                take      = 1'b1;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // A new address phase can only land on a cycle where this slave is ready.
        if (take && accept) begin
            state_d = legal ? S_ACCESS : S_ERR1;
            addr_d  = bus.HADDR;
            write_d = bus.HWRITE;
            strb_d  = legal ? strb_new : '0;
            cnt_d   = '0;
        end
    end

    assign bus.rif_addr  = addr_q;
    assign bus.rif_wstrb = strb_q;
endmodule
